demux_dispatch_ctrl: RTL and testbench

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

---
 rtl/demux_dispatch_pkg.sv | 13 +
 rtl/one_to_four_demux_gatelevel_module.sv | 23 ++
 rtl/demux_dispatch_ctrl.sv | 134 +++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatch_pkg.sv
// Shared types and sizes for the demux dispatch controller.
package demux_dispatch_pkg;

  localparam int unsigned NUM_DEST   = 4;
  localparam int unsigned DEST_W     = 2;
  localparam int unsigned XFER_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/one_to_four_demux_gatelevel_module.sv
// 1-to-4 demultiplexer built from gate primitives: routes a to y[{s1,s0}].
module one_to_four_demux_gatelevel_module (
  input  logic a,
  input  logic s0,
  input  logic s1,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  logic s0_n;
  logic s1_n;

  not u_not_s0 (s0_n, s0);
  not u_not_s1 (s1_n, s1);

  and u_and_y0 (y0, a, s1_n, s0_n);
  and u_and_y1 (y1, a, s1_n, s0);
  and u_and_y2 (y2, a, s1,   s0_n);
  and u_and_y3 (y3, a, s1,   s0);

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-word dispatcher: latches one upstream word and presents it to one of four
// destinations (explicit or round-robin). Optional stall timeout: DISPATCH_TIMEOUT_EN.
module demux_dispatch_ctrl
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_rr,
  input  logic [DEST_W-1:0]     in_dest,
  output logic [NUM_DEST-1:0]   out_valid,
  input  logic [NUM_DEST-1:0]   out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [DEST_W-1:0]     sel,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  drop_pulse,
  output logic [NUM_DEST-1:0]   err_sticky
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [DEST_W-1:0] dest_q;
  logic [DEST_W-1:0] rr_ptr;
  logic              rr_word_q;
  logic              send_valid;
  logic              accept_c;
  logic              done_c;
  logic              drop_c;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SEND;
      SEND:    if (done_c || drop_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / handshake decode; a ready in the timeout cycle completes the transfer
  always_comb begin
    in_ready   = 1'b0;
    send_valid = 1'b0;
    accept_c   = 1'b0;
    done_c     = 1'b0;
    drop_c     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept_c = in_valid;
      end
      SEND: begin
        send_valid = 1'b1;
        done_c     = out_ready[dest_q];
`ifdef DISPATCH_TIMEOUT_EN
        drop_c     = !out_ready[dest_q] && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`endif
      end
      default: ;
    endcase
  end

  // Word/destination capture, transfer count and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      dest_q    <= '0;
      rr_word_q <= 1'b0;
      rr_ptr    <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (accept_c) begin
        data_q    <= in_data;
        dest_q    <= in_rr ? rr_ptr : in_dest;
        rr_word_q <= in_rr;
      end
      if (done_c) xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
      if ((done_c || drop_c) && rr_word_q) rr_ptr <= rr_ptr + DEST_W'(1);
    end
  end

  assign out_data = data_q;
  assign sel      = dest_q;

  one_to_four_demux_gatelevel_module u_demux (
    .a  (send_valid),
    .s0 (sel[0]),
    .s1 (sel[1]),
    .y0 (out_valid[0]),
    .y1 (out_valid[1]),
    .y2 (out_valid[2]),
    .y3 (out_valid[3])
  );

`ifdef DISPATCH_TIMEOUT_EN
  // Stall counter, drop pulse and sticky per-destination error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt    <= '0;
      drop_pulse <= 1'b0;
      err_sticky <= '0;
    end else begin
      drop_pulse <= drop_c;
      if (accept_c)                             tmo_cnt <= '0;
      else if (send_valid && !out_ready[dest_q]) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (drop_c) err_sticky[dest_q] <= 1'b1;
    end
  end
`else
  assign drop_pulse = 1'b0;
  assign err_sticky = '0;

  // TIMEOUT only matters when the stall timeout is built in
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl; adapts timeout expectations to DISPATCH_TIMEOUT_EN.
module tb_demux_dispatch_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_rr;
  logic [1:0] in_dest;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic [7:0] xfer_cnt;
  logic       drop_pulse;
  logic [3:0] err_sticky;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [7:0]  exp_cnt;
  logic [3:0]  exp_err;

  demux_dispatch_ctrl #(.DATA_W(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_rr      (in_rr),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sel        (sel),
    .xfer_cnt   (xfer_cnt),
    .drop_pulse (drop_pulse),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One word with every destination ready: 1 cycle in SEND, then back in IDLE.
  task automatic do_xfer(input logic rr, input logic [1:0] dest, input logic [7:0] data,
                         input logic [1:0] exp_dest);
    in_valid  = 1'b1;
    in_rr     = rr;
    in_dest   = dest;
    in_data   = data;
    out_ready = 4'hF;
    check("xfer_idle_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("xfer_valid", 32'(out_valid), 32'd1 << exp_dest);
    check("xfer_sel", 32'(sel), 32'(exp_dest));
    check("xfer_data", 32'(out_data), 32'(data));
    check("xfer_busy", 32'(in_ready), 0);
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    check("xfer_done_valid", 32'(out_valid), 0);
    check("xfer_no_drop", 32'(drop_pulse), 0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    exp_cnt   = 8'd0;
    exp_err   = 4'd0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_rr     = 1'b0;
    in_dest   = 2'd0;
    out_ready = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 0);
    check("rst_drop", 32'(drop_pulse), 0);
    check("rst_err", 32'(err_sticky), 0);

    // Explicit route to destination 2
    in_valid = 1'b1; in_rr = 1'b0; in_dest = 2'd2; in_data = 8'hA5; out_ready = 4'b0100;
    step();
    in_valid = 1'b0;
    check("route_valid", 32'(out_valid), 'b0100);
    check("route_sel", 32'(sel), 2);
    check("route_data", 32'(out_data), 'hA5);
    check("route_in_ready", 32'(in_ready), 0);
    step();
    exp_cnt = 8'd1;
    check("route_cnt", 32'(xfer_cnt), 1);
    check("route_in_ready_back", 32'(in_ready), 1);

    // Round-robin 0,1,2,3,0 (in_dest ignored)
    for (int i = 0; i < 5; i++) do_xfer(1'b1, 2'd3, 8'(8'h10 + i), 2'(i % 4));

    // Explicit word must not move the round-robin pointer
    do_xfer(1'b0, 2'd3, 8'h77, 2'd3);

    // Backpressure on dest 1; other ready bits high and upstream churn are ignored
    in_valid = 1'b1; in_rr = 1'b0; in_dest = 2'd1; in_data = 8'h3C; out_ready = 4'b1101;
    step();
    in_data = 8'hFF; in_dest = 2'd0; in_rr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", 32'(out_valid), 'b0010);
      check("bp_data", 32'(out_data), 'h3C);
      check("bp_sel", 32'(sel), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b0010;
    check("bp_release_valid", 32'(out_valid), 'b0010);
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("bp_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    check("bp_in_ready_back", 32'(in_ready), 1);

    // Pointer advanced five times from 0, so next round-robin word goes to 1
    do_xfer(1'b1, 2'd0, 8'h5A, 2'd1);

    // Ready arrives in the cycle the stall counter reaches its limit: completes
    in_valid = 1'b1; in_rr = 1'b0; in_dest = 2'd2; in_data = 8'hC3; out_ready = 4'b1011;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("rw_still_send", 32'(out_valid), 'b0100);
    out_ready = 4'b0100;
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("rw_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    check("rw_no_drop", 32'(drop_pulse), 0);
    check("rw_err", 32'(err_sticky), 0);

    // Destination 3 never ready
    in_valid = 1'b1; in_rr = 1'b0; in_dest = 2'd3; in_data = 8'h99; out_ready = 4'b0111;
    step();
    in_valid = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      check("to_send_valid", 32'(out_valid), 'b1000);
      check("to_no_drop_yet", 32'(drop_pulse), 0);
      step();
    end
    exp_err = 4'b1000;
    check("to_drop", 32'(drop_pulse), 1);
    check("to_valid_off", 32'(out_valid), 0);
    check("to_in_ready", 32'(in_ready), 1);
    check("to_err", 32'(err_sticky), 32'(exp_err));
    check("to_cnt_same", 32'(xfer_cnt), 32'(exp_cnt));
    step();
    check("to_drop_once", 32'(drop_pulse), 0);
    check("to_err_sticky", 32'(err_sticky), 32'(exp_err));
`else
    for (int i = 0; i < 20; i++) begin
      check("to_send_valid", 32'(out_valid), 'b1000);
      check("to_no_drop", 32'(drop_pulse), 0);
      step();
    end
    check("to_err_zero", 32'(err_sticky), 0);
    check("to_cnt_same", 32'(xfer_cnt), 32'(exp_cnt));
    out_ready = 4'b1000;
    step();
    exp_cnt = exp_cnt + 8'd1;
    check("to_release_cnt", 32'(xfer_cnt), 32'(exp_cnt));
`endif

    // Reset while holding a word
    in_valid = 1'b1; in_rr = 1'b0; in_dest = 2'd0; in_data = 8'hE1; out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    check("rs_send", 32'(out_valid), 'b0001);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    exp_cnt = 8'd0;
    check("rs_in_ready", 32'(in_ready), 1);
    check("rs_valid", 32'(out_valid), 0);
    check("rs_cnt", 32'(xfer_cnt), 0);
    check("rs_err", 32'(err_sticky), 0);
    check("rs_out_data", 32'(out_data), 0);

    // 256 round-robin transfers wrap the counter back to zero
    for (int i = 0; i < 256; i++) do_xfer(1'b1, 2'd2, 8'(i), 2'(i % 4));
    check("wrap_cnt", 32'(xfer_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
